// File: rtl/usb_hid_report_gen.sv
// usb_hid_report_gen
// Boot-protocol mouse report builder feeding the HID IN endpoint (EP1).
// Relative motion is accumulated with saturation. Each report is a snapshot
// of the buttons plus motion clamped to +/-127, and any residual carries into
// the next report. Bytes are streamed over a valid/ready handshake, and valid
// drops after the last byte to mark the packet end.
// Optional feature: define HID_WHEEL_EN for a 4-byte report that carries a
// saturating 8-bit wheel accumulator in byte 3.
module usb_hid_report_gen #(
    parameter int ACC_W   = 16,
    parameter int MIN_GAP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             usb_configured,
    input  logic [2:0]       buttons,
    input  logic             mv_valid,
    input  logic [ACC_W-1:0] mv_dx,
    input  logic [ACC_W-1:0] mv_dy,
    input  logic [7:0]       mv_wheel,
    output logic [7:0]       hid_tx_data,
    output logic             hid_tx_valid,
    input  logic             hid_tx_ready,
    output logic             report_pending
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SNAP,
        ST_SEND,
        ST_GAP
    } state_t;

    // Accumulator limits are symmetric, so -(2^(ACC_W-1)) is never stored.
    localparam logic signed [ACC_W:0]   ACC_MAX  = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0]   ACC_MIN  = -ACC_MAX;
    localparam logic signed [ACC_W-1:0] REP_MAX  = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] REP_MIN  = -REP_MAX;
    localparam logic [7:0]              GAP_LAST = 8'(MIN_GAP - 1);
`ifdef HID_WHEEL_EN
    localparam logic [1:0]              LAST_IDX = 2'd3;
`else
    localparam logic [1:0]              LAST_IDX = 2'd2;
`endif

    state_t           r_state;
    logic [1:0]       r_idx;
    logic [7:0]       r_gap;
    logic [7:0]       r_data;
    logic             r_valid;
    logic [7:0]       r_byte1;
    logic [7:0]       r_byte2;
    logic [2:0]       r_last_buttons;
    logic [ACC_W-1:0] r_acc_x;
    logic [ACC_W-1:0] r_acc_y;

    logic                  w_snap;
    logic                  w_pending;
    logic                  w_w_nz;
    logic [7:0]            w_rep_x;
    logic [7:0]            w_rep_y;
    logic signed [ACC_W:0] w_ax_ext;
    logic signed [ACC_W:0] w_ay_ext;
    logic signed [ACC_W:0] w_dx_add;
    logic signed [ACC_W:0] w_dy_add;
    logic signed [ACC_W:0] w_rx_sub;
    logic signed [ACC_W:0] w_ry_sub;
    logic signed [ACC_W:0] w_x_sum;
    logic signed [ACC_W:0] w_y_sum;
    logic [7:0]            w_next_byte;

    // Saturate an ACC_W+1 bit intermediate back into the accumulator range.
    function automatic logic [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] v);
        if (v > ACC_MAX) begin
            return ACC_MAX[ACC_W-1:0];
        end else if (v < ACC_MIN) begin
            return ACC_MIN[ACC_W-1:0];
        end
        return v[ACC_W-1:0];
    endfunction

    // Portion of an accumulator that fits in one report byte.
    function automatic logic [7:0] clamp_rep(input logic [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] s;
        s = $signed(a);
        if (s > REP_MAX) begin
            return 8'h7F;
        end else if (s < REP_MIN) begin
            return 8'h81;
        end
        return a[7:0];
    endfunction

    assign w_snap  = (r_state == ST_SNAP);
    assign w_rep_x = clamp_rep(r_acc_x);
    assign w_rep_y = clamp_rep(r_acc_y);

    // One adder per axis: plain accumulate, or subtract the reported part during SNAP.
    assign w_ax_ext = $signed({r_acc_x[ACC_W-1], r_acc_x});
    assign w_ay_ext = $signed({r_acc_y[ACC_W-1], r_acc_y});
    assign w_dx_add = mv_valid ? $signed({mv_dx[ACC_W-1], mv_dx}) : '0;
    assign w_dy_add = mv_valid ? $signed({mv_dy[ACC_W-1], mv_dy}) : '0;
    assign w_rx_sub = w_snap ? $signed({{(ACC_W-7){w_rep_x[7]}}, w_rep_x}) : '0;
    assign w_ry_sub = w_snap ? $signed({{(ACC_W-7){w_rep_y[7]}}, w_rep_y}) : '0;
    assign w_x_sum  = w_ax_ext - w_rx_sub + w_dx_add;
    assign w_y_sum  = w_ay_ext - w_ry_sub + w_dy_add;

`ifdef HID_WHEEL_EN
    logic [7:0]      r_acc_w;
    logic [7:0]      r_byte3;
    logic signed [8:0] w_w_base;
    logic signed [8:0] w_w_add;
    logic signed [8:0] w_w_sum;
    logic [7:0]      w_w_new;

    // The wheel is fully consumed by each report, so SNAP restarts it from zero.
    assign w_w_base = w_snap ? '0 : $signed({r_acc_w[7], r_acc_w});
    assign w_w_add  = mv_valid ? $signed({mv_wheel[7], mv_wheel}) : '0;
    assign w_w_sum  = w_w_base + w_w_add;
    assign w_w_new  = (w_w_sum > 9'sd127)  ? 8'h7F :
                      (w_w_sum < -9'sd127) ? 8'h81 : w_w_sum[7:0];
    assign w_w_nz   = (r_acc_w != 8'h00);
`else
    logic w_unused_wheel;

    assign w_unused_wheel = ^mv_wheel;
    assign w_w_nz         = 1'b0;
`endif

    assign w_pending = (r_acc_x != '0) | (r_acc_y != '0) | w_w_nz |
                       (buttons != r_last_buttons);

    // Select the report byte that follows the one currently on the bus.
    always_comb begin
        // NOTE: a default before the case means every path assigns, so no latch is inferred.
        w_next_byte = 8'h00;
        case (r_idx)
            2'd0:    w_next_byte = r_byte1;
            2'd1:    w_next_byte = r_byte2;
`ifdef HID_WHEEL_EN
            2'd2:    w_next_byte = r_byte3;
`endif
            default: w_next_byte = 8'h00;
        endcase
    end

    // Motion accumulators: always summing; flushed while unconfigured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
            r_acc_x <= '0;
            r_acc_y <= '0;
`ifdef HID_WHEEL_EN
            r_acc_w <= '0;
`endif
        end else if (!usb_configured) begin
            r_acc_x <= '0;
            r_acc_y <= '0;
`ifdef HID_WHEEL_EN
            r_acc_w <= '0;
`endif
        end else begin
            r_acc_x <= sat_acc(w_x_sum);
            r_acc_y <= sat_acc(w_y_sum);
`ifdef HID_WHEEL_EN
            r_acc_w <= w_w_new;
`endif
        end
    end

    // Report FSM: snapshot, byte streaming with registered handshake outputs, inter-report gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_idx          <= '0;
            r_gap          <= '0;
            r_data         <= '0;
            r_valid        <= 1'b0;
            r_byte1        <= '0;
            r_byte2        <= '0;
            r_last_buttons <= '0;
`ifdef HID_WHEEL_EN
            r_byte3        <= '0;
`endif
        end else if (!usb_configured) begin
            // Abandon any partial report; nothing is resumed after reconfiguration.
            r_state        <= ST_IDLE;
            r_idx          <= '0;
            r_gap          <= '0;
            r_data         <= '0;
            r_valid        <= 1'b0;
            r_last_buttons <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pending) begin
                        r_state <= ST_SNAP;
                    end
                end
                ST_SNAP: begin
                    r_byte1        <= w_rep_x;
                    r_byte2        <= w_rep_y;
`ifdef HID_WHEEL_EN
                    r_byte3        <= r_acc_w;
`endif
                    r_last_buttons <= buttons;
                    r_idx          <= '0;
                    r_data         <= {5'b0, buttons};
                    r_valid        <= 1'b1;
                    r_state        <= ST_SEND;
                end
                ST_SEND: begin
                    if (hid_tx_ready) begin
                        if (r_idx == LAST_IDX) begin
                            r_valid <= 1'b0;
                            r_data  <= '0;
                            r_gap   <= '0;
                            r_state <= ST_GAP;
                        end else begin
                            r_idx  <= r_idx + 2'd1;
                            r_data <= w_next_byte;
                        end
                    end
                end
                ST_GAP: begin
                    if (r_gap == GAP_LAST) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap <= r_gap + 8'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign hid_tx_data    = r_data;
    assign hid_tx_valid   = r_valid;
    assign report_pending = w_pending;

endmodule

// File: tb/tb_usb_hid_report_gen.sv
// Self-checking bench for usb_hid_report_gen: a transaction-level model
// (integer accumulators, a queue of outstanding report bytes, a cooldown count)
// is compared against the DUT on every negedge, plus directed literal checks.
`timescale 1ns/1ps
module tb_usb_hid_report_gen;
    localparam int ACC_W   = 16;
    localparam int MIN_GAP = 4;
    localparam int MAXV    = (1 << (ACC_W - 1)) - 1;
`ifdef HID_WHEEL_EN
    localparam int NBYTES  = 4;
`else
    localparam int NBYTES  = 3;
`endif

    logic             clk            = 1'b0;
    logic             rst_n          = 1'b0;
    logic             usb_configured = 1'b0;
    logic [2:0]       buttons        = 3'b000;
    logic             mv_valid       = 1'b0;
    logic [ACC_W-1:0] mv_dx          = '0;
    logic [ACC_W-1:0] mv_dy          = '0;
    logic [7:0]       mv_wheel       = 8'h00;
    logic             hid_tx_ready   = 1'b0;
    logic [7:0]       hid_tx_data;
    logic             hid_tx_valid;
    logic             report_pending;

    int n_checks = 0;
    int n_fail   = 0;

    usb_hid_report_gen #(.ACC_W(ACC_W), .MIN_GAP(MIN_GAP)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .usb_configured (usb_configured),
        .buttons        (buttons),
        .mv_valid       (mv_valid),
        .mv_dx          (mv_dx),
        .mv_dy          (mv_dy),
        .mv_wheel       (mv_wheel),
        .hid_tx_data    (hid_tx_data),
        .hid_tx_valid   (hid_tx_valid),
        .hid_tx_ready   (hid_tx_ready),
        .report_pending (report_pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_ax = 0, m_ay = 0, m_aw = 0;
    logic [2:0] m_lb = 3'b000;
    logic [7:0] m_q[$];
    int         m_cool = 0;
    bit         m_snap = 1'b0;

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : ((v < -lim) ? -lim : v);
    endfunction

    function automatic bit m_pending();
        bit p;
        p = (m_ax != 0) || (m_ay != 0) || (buttons != m_lb);
`ifdef HID_WHEEL_EN
        p = p || (m_aw != 0);
`endif
        return p;
    endfunction

    task automatic model_clear();
        m_ax = 0; m_ay = 0; m_aw = 0; m_lb = 3'b000;
        m_q.delete(); m_cool = 0; m_snap = 1'b0;
    endtask

    task automatic model_step();
        int dx, dy, dw, rx, ry;
        bit pend;
        if (!rst_n || !usb_configured) begin
            model_clear();
            return;
        end
        dx = mv_valid ? int'($signed(mv_dx)) : 0;
        dy = mv_valid ? int'($signed(mv_dy)) : 0;
`ifdef HID_WHEEL_EN
        dw = mv_valid ? int'($signed(mv_wheel)) : 0;
`else
        dw = 0;
`endif
        pend = m_pending();
        if (m_snap) begin
            rx = sat(m_ax, 127);
            ry = sat(m_ay, 127);
            m_q.push_back({5'b0, buttons});
            m_q.push_back(8'(rx));
            m_q.push_back(8'(ry));
            if (NBYTES == 4) m_q.push_back(8'(m_aw));
            m_ax = sat(m_ax - rx + dx, MAXV);
            m_ay = sat(m_ay - ry + dy, MAXV);
            m_aw = sat(dw, 127);
            m_lb = buttons;
            m_snap = 1'b0;
        end else begin
            m_ax = sat(m_ax + dx, MAXV);
            m_ay = sat(m_ay + dy, MAXV);
            m_aw = sat(m_aw + dw, 127);
            if (m_q.size() != 0) begin
                if (hid_tx_ready) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) m_cool = MIN_GAP;
                end
            end else if (m_cool > 0) begin
                m_cool--;
            end else if (pend) begin
                m_snap = 1'b1;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    // Per-cycle compare against the model.
    initial forever begin
        @(negedge clk);
        check("valid", hid_tx_valid, m_q.size() != 0);
        if (m_q.size() != 0) check("data", hid_tx_data, m_q[0]);
        check("pending", report_pending, m_pending());
    end

    // Accepted-byte log and inter-report gap monitor.
    logic [7:0] log_q[$];
    int         low_run = 0;
    bit         seen_rep = 1'b0;
    initial forever begin
        @(negedge clk);
        if (rst_n && usb_configured && hid_tx_valid && hid_tx_ready) log_q.push_back(hid_tx_data);
        if (!rst_n || !usb_configured) begin
            seen_rep = 1'b0; low_run = 0;
        end else if (hid_tx_valid) begin
            if (seen_rep && low_run > 0) check("gap_len_ge_min", low_run >= MIN_GAP, 1'b1);
            seen_rep = 1'b1; low_run = 0;
        end else begin
            low_run++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic move(input int dx, input int dy, input int dw);
        @(posedge clk); #1;
        mv_valid = 1'b1; mv_dx = ACC_W'(dx); mv_dy = ACC_W'(dy); mv_wheel = 8'(dw);
        @(posedge clk); #1;
        mv_valid = 1'b0; mv_dx = '0; mv_dy = '0; mv_wheel = 8'h00;
    endtask

    task automatic wait_quiet(input string name, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(m_q.size() == 0 && m_cool == 0 && !m_snap && !m_pending() && !hid_tx_valid) && n < budget);
        if (n >= budget) begin
            n_checks++; n_fail++;
            $display("FAIL %s_timeout: not idle after %0d cycles", name, budget);
        end
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        @(negedge clk);
        while (!hid_tx_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, "_valid_rise"}, hid_tx_valid, 1'b1);
    endtask

    task automatic check_log(input string name, input int n, input logic [7:0] e0,
                             input logic [7:0] e1, input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] e[4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        check({name, "_len"}, log_q.size(), n);
        for (int i = 0; i < n && i < log_q.size(); i++)
            check($sformatf("%s_b%0d", name, i), log_q[i], e[i]);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int sx, sy, cfg_hold;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", hid_tx_valid, 1'b0);
        check("rst_data", hid_tx_data, 8'h00);
        check("rst_pending", report_pending, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1; usb_configured = 1'b1; hid_tx_ready = 1'b1;

        // Basic report: dx=5, dy=-3.
        log_q.delete();
        move(5, -3, 0);
        wait_quiet("t1", 100);
        check_log("t1", NBYTES, 8'h00, 8'h05, 8'hFD, 8'h00);
        check("t1_pending_after", report_pending, 1'b0);

        // Large motion split across three reports.
        log_q.delete();
        move(300, 0, 0);
        wait_quiet("t2", 200);
        check("t2_len", log_q.size(), 3 * NBYTES);
        if (log_q.size() == 3 * NBYTES) begin
            check("t2_x0", log_q[1], 8'h7F);
            check("t2_x1", log_q[1 + NBYTES], 8'h7F);
            check("t2_x2", log_q[1 + 2 * NBYTES], 8'h2E);
        end

        // Button change only, then no repeat while held.
        log_q.delete();
        @(posedge clk); #1; buttons = 3'b001;
        wait_quiet("t3", 100);
        check_log("t3", NBYTES, 8'h01, 8'h00, 8'h00, 8'h00);
        repeat (30) @(negedge clk);
        check("t3_no_repeat", log_q.size(), NBYTES);
        @(posedge clk); #1; buttons = 3'b000;
        wait_quiet("t3b", 100);

        // Ready stalled for 10 cycles on byte1.
        log_q.delete();
        hid_tx_ready = 1'b0;
        move(9, 0, 0);
        wait_valid("t4");
        check("t4_byte0", hid_tx_data, 8'h00);
        @(posedge clk); #1; hid_tx_ready = 1'b1;
        @(posedge clk); #1; hid_tx_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t4_stall_valid", hid_tx_valid, 1'b1);
            check("t4_stall_data", hid_tx_data, 8'h09);
        end
        @(posedge clk); #1; hid_tx_ready = 1'b1;
        wait_quiet("t4", 100);
        check_log("t4", NBYTES, 8'h00, 8'h09, 8'h00, 8'h00);

        // Deconfigure during byte1 with residual motion; no report afterwards.
        hid_tx_ready = 1'b0;
        move(200, 0, 0);
        wait_valid("t5");
        @(posedge clk); #1; hid_tx_ready = 1'b1;
        @(posedge clk); #1; hid_tx_ready = 1'b0; usb_configured = 1'b0;
        @(negedge clk);
        check("t5_pending_before_drop", report_pending, 1'b1);
        @(negedge clk);
        check("t5_valid_dropped", hid_tx_valid, 1'b0);
        check("t5_pending_flushed", report_pending, 1'b0);
        @(posedge clk); #1; usb_configured = 1'b1; hid_tx_ready = 1'b1;
        log_q.delete();
        repeat (20) @(negedge clk);
        check("t5_no_report", log_q.size(), 0);

        // Wheel: byte3 only when the wheel feature is built in.
        log_q.delete();
        move(1, 0, -2);
        wait_quiet("t6", 100);
        check_log("t6", NBYTES, 8'h00, 8'h01, 8'h00, 8'hFE);

        // Saturation: two full-scale strobes yield exactly one full-scale total.
        log_q.delete();
        @(posedge clk); #1;
        mv_valid = 1'b1; mv_dx = ACC_W'(MAXV); mv_dy = ACC_W'(-MAXV - 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        mv_valid = 1'b0; mv_dx = '0; mv_dy = '0;
        wait_quiet("t7", 6000);
        sx = 0; sy = 0;
        for (int i = 0; i + 2 < log_q.size(); i += NBYTES) begin
            sx += int'($signed(log_q[i + 1]));
            sy += int'($signed(log_q[i + 2]));
        end
        check("t7_sum_x", sx, MAXV);
        check("t7_sum_y", sy, -MAXV);

        // Async reset in the middle of a report.
        hid_tx_ready = 1'b0;
        move(50, 0, 0);
        wait_valid("t8");
        #2 rst_n = 1'b0;
        #1;
        check("t8_valid_async", hid_tx_valid, 1'b0);
        check("t8_data_async", hid_tx_data, 8'h00);
        check("t8_pending_async", report_pending, 1'b0);
        @(posedge clk); #1; rst_n = 1'b1; hid_tx_ready = 1'b1;

        // Randomized traffic against the model.
        cfg_hold = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            mv_valid = ($urandom_range(2) == 0);
            mv_dx    = ($urandom_range(7) == 0) ? ACC_W'($urandom) : ACC_W'(int'($urandom_range(400)) - 200);
            mv_dy    = ($urandom_range(7) == 0) ? ACC_W'($urandom) : ACC_W'(int'($urandom_range(400)) - 200);
            mv_wheel = 8'($urandom);
            if ($urandom_range(39) == 0) buttons = 3'($urandom);
            hid_tx_ready = ($urandom_range(3) != 0);
            if (cfg_hold == 0 && $urandom_range(299) == 0) cfg_hold = $urandom_range(5, 1);
            usb_configured = (cfg_hold == 0);
            if (cfg_hold > 0) cfg_hold--;
        end
        @(posedge clk); #1;
        mv_valid = 1'b0; usb_configured = 1'b1; hid_tx_ready = 1'b1; buttons = 3'b000;
        wait_quiet("t9", 8000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/usb_hid_report_gen.md
Name: usb_hid_report_gen

Overview:
- Upstream feeder for the USB device core's HID IN endpoint (EP1).
- Accumulates relative mouse motion and button state from the sensor/emulation front end, then builds a boot-protocol mouse report.
- Streams the report byte-by-byte over the hid_tx_data/hid_tx_valid/hid_tx_ready handshake. Deasserting valid after the last byte marks the packet end for the core.

Parameters:
- ACC_W, 16: signed width of each motion accumulator and motion input.
- MIN_GAP, 4: minimum clk cycles hid_tx_valid stays low between two reports (1..255).

Ports:
- clk, input, 1: system clock (48 MHz domain, same as device core).
- rst_n, input, 1: asynchronous active-low reset.
- usb_configured, input, 1: from device core; 0 holds the block inactive and flushed.
- buttons, input, 3: live button levels {middle, right, left}, sampled only at snapshot.
- mv_valid, input, 1: one-cycle strobe, motion delta present.
- mv_dx, input, ACC_W: signed X delta.
- mv_dy, input, ACC_W: signed Y delta.
- mv_wheel, input, 8: signed wheel delta; used only with HID_WHEEL_EN.
- hid_tx_data, output, 8: current report byte.
- hid_tx_valid, output, 1: byte available; held high across all bytes of one report.
- hid_tx_ready, input, 1: core accepted the current byte this cycle.
- report_pending, output, 1: accumulators nonzero or buttons differ from last sent.

Behaviour:
- Reset values: hid_tx_data=0, hid_tx_valid=0, report_pending=0. Accumulators, last_buttons, byte index and gap counter all 0. State IDLE.
- Accumulate: on mv_valid, acc_x += mv_dx and acc_y += mv_dy, computed at ACC_W+1 bits and saturated to [-(2^(ACC_W-1)-1), +(2^(ACC_W-1)-1)].
- report_pending = (acc_x!=0)|(acc_y!=0)|(acc_w!=0 if wheel enabled)|(buttons!=last_buttons). It is combinational from registered state plus the buttons input.
- FSM states: IDLE, SNAP, SEND, GAP.
- IDLE -> SNAP when usb_configured && report_pending.
- SNAP (exactly 1 cycle):
  - rep_x = clamp(acc_x, -127, +127); rep_y likewise.
  - Report regs loaded: byte0={5'b0,buttons}, byte1=rep_x[7:0], byte2=rep_y[7:0].
  - acc_x <= acc_x - rep_x (+ mv_dx if mv_valid this cycle, saturated); Y likewise. Residual carries into the next report.
  - last_buttons <= buttons. Byte index <= 0.
  - Next state SEND.
- SEND:
  - hid_tx_valid=1, hid_tx_data=report[idx].
  - Data must stay stable while valid && !ready.
  - On ready: idx++. When the last byte (idx=2, or 3 with wheel) is accepted, valid drops the next cycle and the FSM goes to GAP.
  - Motion arriving during SEND accumulates normally.
- GAP: valid=0 for MIN_GAP cycles (counter), then IDLE.
- Latency: pending in IDLE -> first valid byte = 2 cycles (IDLE->SNAP->SEND).
- usb_configured low in any state: next cycle state=IDLE, valid=0, accumulators and last_buttons cleared, mv_valid ignored while low. A partial report is abandoned, not resumed.
- Async reset mid-report: outputs return to reset values immediately.
- Saturation boundary: acc at +max plus positive delta stays at +max. No wrap-around permitted.
- Large motion: acc_x=300 yields successive reports of 127, 127, 46 with no loss.
- No retransmit logic: once a byte is handed over, its content is committed.

Optional Feature:
- Macro HID_WHEEL_EN.
- Defined:
  - 8-bit signed wheel accumulator acc_w with saturation to ±127; mv_wheel is summed on mv_valid.
  - 4-byte report; byte3 = acc_w, fully consumed (acc_w cleared at SNAP, plus any same-cycle mv_wheel).
  - acc_w counts toward report_pending.
- Undefined:
  - mv_wheel ignored, no wheel register.
  - 3-byte report; last byte index is 2.

Test Plan:
- Reset, configured=1, mv_valid with dx=5, dy=-3, buttons=0 -> bytes 0x00,0x05,0xFD with valid continuous. Valid low ≥MIN_GAP cycles, then report_pending=0.
- dx=300 single strobe, ready always 1 -> three reports with X bytes 0x7F, 0x7F, 0x2E. Accumulator 0 after the third.
- Buttons change 000->001, no motion -> one report 0x01,0x00,0x00. No further report while buttons stay 001.
- hid_tx_ready low for 10 cycles on byte1 -> hid_tx_data holds byte1 and valid stays 1 throughout. Sequence completes after ready returns.
- usb_configured drops during byte1 of a pending report -> valid=0 next cycle, accumulators 0. Reconfigure with no motion -> no report.
- HID_WHEEL_EN defined, mv_wheel=-2 with dx=1 -> 4 bytes 0x00,0x01,0x00,0xFE. Undefined -> 3 bytes, wheel ignored.
